// File: rtl/can_err_pkg.sv
// rtl/can_err_pkg.sv - shared types and constants for CAN fault confinement
package can_err_pkg;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        PASSIVE = 2'd1,
        BUS_OFF = 2'd2
    } err_state_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLAG       = 2'd1,
        DELIM_WAIT = 2'd2,
        DELIM      = 2'd3
    } frame_state_t;

    localparam int TEC_TX_INC    = 8;
    localparam int REC_RX_INC    = 1;
    localparam int REC_RESTORE   = 120;
    localparam int WARN_LIM      = 96;
    localparam int RECESSIVE_RUN = 11;

endpackage

// File: rtl/can_fault_confinement_if.sv
// rtl/can_fault_confinement_if.sv - field-checker/bit-driver bundle; CAN_ERR_WARN_EN adds err_warn
interface can_fault_confinement_if;
    import can_err_pkg::*;

    logic       sp;
    logic       rx_bit;
    logic       tx_mode;
    logic       stf_e_n;
    logic       eof_e_n;
    logic       crc_e_n;
    logic       frm_e_n;
    logic       bit_e_n;
    logic       rx_ok;
    logic       tx_ok;
    logic       tx_drive_n;
    logic       error_n;
    err_state_t err_state;
    logic [8:0] tec;
    logic [7:0] rec;
`ifdef CAN_ERR_WARN_EN
    logic       err_warn;
`endif

    modport master (
`ifdef CAN_ERR_WARN_EN
        input  err_warn,
`endif
        output sp, rx_bit, tx_mode, stf_e_n, eof_e_n, crc_e_n, frm_e_n, bit_e_n, rx_ok, tx_ok,
        input  tx_drive_n, error_n, err_state, tec, rec
    );

    modport slave (
`ifdef CAN_ERR_WARN_EN
        output err_warn,
`endif
        input  sp, rx_bit, tx_mode, stf_e_n, eof_e_n, crc_e_n, frm_e_n, bit_e_n, rx_ok, tx_ok,
        output tx_drive_n, error_n, err_state, tec, rec
    );

endinterface

// File: rtl/can_fault_confinement_busoff_recovery.sv
// rtl/can_fault_confinement_busoff_recovery.sv - counts runs of 11 recessive bits while bus-off
module can_busoff_recovery #(
    parameter int RECOV_SEQ = 128
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sp,
    input  logic rx_bit,
    input  logic enable,
    output logic done
);
    import can_err_pkg::*;

    localparam int RW = $clog2(RECOV_SEQ + 1);

    logic [3:0]    bit_cnt;
    logic [RW-1:0] run_cnt;
    logic          run_end;

    assign run_end = enable && sp && rx_bit && (bit_cnt == 4'(RECESSIVE_RUN - 1));
    assign done    = run_end && (run_cnt == RW'(RECOV_SEQ - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            run_cnt <= '0;
        end else if (sp) begin
            if (!enable || !rx_bit) begin
                // a dominant bit only breaks the current run; leaving bus-off forgets everything
                bit_cnt <= '0;
                if (!enable) run_cnt <= '0;
            end else if (run_end) begin
                bit_cnt <= '0;
                run_cnt <= done ? '0 : run_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/can_fault_confinement.sv
// rtl/can_fault_confinement.sv - CAN error counters, node state and error-frame sequencing; CAN_ERR_WARN_EN adds err_warn
module can_fault_confinement #(
    parameter int FLAG_LEN    = 6,
    parameter int DELIM_LEN   = 8,
    parameter int PASSIVE_LIM = 127,
    parameter int BUSOFF_LIM  = 256,
    parameter int RECOV_SEQ   = 128
) (
    input  logic                    clk,
    input  logic                    reset_n,
    can_fault_confinement_if.slave  bus
);
    import can_err_pkg::*;

    frame_state_t state_q, state_d;
    err_state_t   est_q, est_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         entry_passive_q, entry_passive_d;
    logic [8:0]   tec_q, tec_d;
    logic [7:0]   rec_q, rec_d;
    logic         err_hit, err_evt, bus_off, recov_done;

    assign err_hit = bus.sp && !(&{bus.stf_e_n, bus.eof_e_n, bus.crc_e_n, bus.frm_e_n, bus.bit_e_n});
    assign bus_off = (est_q == BUS_OFF);
    assign err_evt = err_hit && (state_q == IDLE) && !bus_off;

    can_busoff_recovery #(.RECOV_SEQ(RECOV_SEQ)) u_recovery (
        .clk     (clk),
        .reset_n (reset_n),
        .sp      (bus.sp),
        .rx_bit  (bus.rx_bit),
        .enable  (bus_off),
        .done    (recov_done)
    );

    always_comb begin
        tec_d = tec_q;
        rec_d = rec_q;
        if (recov_done) begin
            tec_d = '0;
            rec_d = '0;
        end else if (bus.sp && !bus_off) begin
            if (err_evt) begin
                if (bus.tx_mode)
                    tec_d = (tec_q >= 9'(BUSOFF_LIM - TEC_TX_INC)) ? 9'(BUSOFF_LIM)
                                                                   : tec_q + 9'(TEC_TX_INC);
                else
                    rec_d = (rec_q == 8'hFF) ? rec_q : rec_q + 8'(REC_RX_INC);
            end else if (!err_hit) begin
                if (bus.rx_ok) begin
                    if (rec_q > 8'(PASSIVE_LIM)) rec_d = 8'(REC_RESTORE);
                    else if (rec_q != 8'd0)     rec_d = rec_q - 8'd1;
                end
                if (bus.tx_ok && tec_q != 9'd0) tec_d = tec_q - 9'd1;
            end
        end
    end

    // node state follows the counter values being written, so both land on the same edge
    always_comb begin
        if (recov_done)
            est_d = ACTIVE;
        else if (bus_off || tec_d >= 9'(BUSOFF_LIM))
            est_d = BUS_OFF;
        else if (tec_d > 9'(PASSIVE_LIM) || rec_d > 8'(PASSIVE_LIM))
            est_d = PASSIVE;
        else
            est_d = ACTIVE;
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        entry_passive_d = entry_passive_q;
        if (bus.sp) begin
            if (est_d == BUS_OFF || bus_off) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: if (err_evt) begin
                        state_d         = FLAG;
                        cnt_d           = '0;
                        entry_passive_d = (est_q == PASSIVE);
                    end
                    FLAG: if (cnt_q == 4'(FLAG_LEN - 1)) begin
                        state_d = DELIM_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    // dominant bits here are other nodes' superimposed flags
                    DELIM_WAIT: if (bus.rx_bit) begin
                        state_d = DELIM;
                        cnt_d   = 4'd1;
                    end
                    DELIM: if (!bus.rx_bit) begin
                        state_d = DELIM_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == 4'(DELIM_LEN - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            est_q           <= ACTIVE;
            cnt_q           <= '0;
            entry_passive_q <= 1'b0;
            tec_q           <= '0;
            rec_q           <= '0;
        end else begin
            state_q         <= state_d;
            est_q           <= est_d;
            cnt_q           <= cnt_d;
            entry_passive_q <= entry_passive_d;
            tec_q           <= tec_d;
            rec_q           <= rec_d;
        end
    end

    assign bus.error_n    = (state_q == IDLE);
    assign bus.tx_drive_n = !((state_q == FLAG) && !entry_passive_q && !bus_off);
    assign bus.err_state  = est_q;
    assign bus.tec        = tec_q;
    assign bus.rec        = rec_q;

`ifdef CAN_ERR_WARN_EN
    logic warn_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            warn_q <= 1'b0;
        else if (bus.sp)
            warn_q <= !recov_done && (tec_d >= 9'(WARN_LIM) || rec_d >= 8'(WARN_LIM));
    end

    assign bus.err_warn = warn_q;
`endif

endmodule

// File: tb/tb_can_fault_confinement.sv
// tb/tb_can_fault_confinement.sv - scoreboard bench for can_fault_confinement
module tb_can_fault_confinement;
    import can_err_pkg::*;

    localparam logic [4:0] NOF = 5'b11111;
    localparam logic [4:0] STF = 5'b01111;
    localparam logic [4:0] EOF = 5'b10111;
    localparam logic [4:0] CRC = 5'b11011;
    localparam logic [4:0] FRM = 5'b11101;
    localparam logic [4:0] BIT = 5'b11110;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    can_fault_confinement_if bus();

    can_fault_confinement dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        int         seq;
        logic [8:0] tec;
        logic [7:0] rec;
        logic [1:0] st;
        logic       en;
        logic       dn;
    } exp_t;

    exp_t  q[$];
    string names[$];
    int    n_cmp     = 0;
    int    n_bad     = 0;
    int    sp_issued = 0;
    int    sp_seen   = 0;

    task automatic compare_front();
        exp_t  e;
        string nm;
        logic  bad;
        logic  w_exp;
        e  = q.pop_front();
        nm = names.pop_front();
        w_exp = (e.tec >= 9'd96) || (e.rec >= 8'd96);
        bad = (bus.tec !== e.tec) || (bus.rec !== e.rec) || (bus.err_state !== e.st) ||
              (bus.error_n !== e.en) || (bus.tx_drive_n !== e.dn);
`ifdef CAN_ERR_WARN_EN
        bad = bad || (bus.err_warn !== w_exp);
`endif
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got tec=%0d rec=%0d st=%0d error_n=%b tx_drive_n=%b, want tec=%0d rec=%0d st=%0d error_n=%b tx_drive_n=%b warn=%b",
                     nm, bus.tec, bus.rec, bus.err_state, bus.error_n, bus.tx_drive_n,
                     e.tec, e.rec, e.st, e.en, e.dn, w_exp);
        end
    endtask

    // monitor: outputs are compared 1ns after the sp edge they belong to, or after reset falls
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                #1;
                while (q.size() > 0 && q[0].seq < 0) compare_front();
            end else if (bus.sp) begin
                sp_seen++;
                #1;
                while (q.size() > 0 && q[0].seq == sp_seen) compare_front();
            end
        end
    end

    task automatic chk(input string nm, input int t, input int r, input int s,
                       input logic en, input logic dn, input bit async_chk = 1'b0);
        exp_t e;
        e.seq = async_chk ? -1 : sp_issued + 1;
        e.tec = 9'(t);
        e.rec = 8'(r);
        e.st  = 2'(s);
        e.en  = en;
        e.dn  = dn;
        q.push_back(e);
        names.push_back(nm);
    endtask

    task automatic drive_bit(input logic rx, input logic [4:0] fl, input logic txm,
                             input logic rxok, input logic txok);
        @(negedge clk);
        bus.rx_bit  = rx;
        {bus.stf_e_n, bus.eof_e_n, bus.crc_e_n, bus.frm_e_n, bus.bit_e_n} = fl;
        bus.tx_mode = txm;
        bus.rx_ok   = rxok;
        bus.tx_ok   = txok;
        bus.sp      = 1'b1;
        sp_issued++;
        @(negedge clk);
        bus.sp      = 1'b0;
        {bus.stf_e_n, bus.eof_e_n, bus.crc_e_n, bus.frm_e_n, bus.bit_e_n} = NOF;
        bus.rx_ok   = 1'b0;
        bus.tx_ok   = 1'b0;
        bus.rx_bit  = 1'b1;
        @(negedge clk);
    endtask

    task automatic rbit(input logic rx);
        drive_bit(rx, NOF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finish_frame();
        repeat (6) rbit(1'b0);
        repeat (8) rbit(1'b1);
    endtask

    task automatic err_frame(input logic [4:0] fl, input logic txm);
        drive_bit(1'b0, fl, txm, 1'b0, 1'b0);
        finish_frame();
    endtask

    task automatic do_reset(input string nm);
        chk(nm, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sp = 1'b0; bus.rx_bit = 1'b1; bus.tx_mode = 1'b0;
        bus.rx_ok = 1'b0; bus.tx_ok = 1'b0;
        {bus.stf_e_n, bus.eof_e_n, bus.crc_e_n, bus.frm_e_n, bus.bit_e_n} = NOF;

        do_reset("reset_state");

        // receive error, full error frame
        chk("t1_err", 0, 1, 0, 1'b0, 1'b0); drive_bit(1'b0, CRC, 1'b0, 1'b0, 1'b0);
        repeat (4) rbit(1'b0);
        chk("t1_flag5", 0, 1, 0, 1'b0, 1'b0); rbit(1'b0);
        chk("t1_flag6", 0, 1, 0, 1'b0, 1'b1); rbit(1'b0);
        repeat (6) rbit(1'b1);
        chk("t1_delim7", 0, 1, 0, 1'b0, 1'b1); rbit(1'b1);
        chk("t1_delim8", 0, 1, 0, 1'b1, 1'b1); rbit(1'b1);

        // two flags in one sp count once; errors ignored inside the frame; dominant restarts delimiter
        chk("t2_multi", 8, 1, 0, 1'b0, 1'b0); drive_bit(1'b0, STF & FRM, 1'b1, 1'b0, 1'b0);
        rbit(1'b0);
        chk("t2_ignored_in_flag", 8, 1, 0, 1'b0, 1'b0); drive_bit(1'b0, CRC, 1'b1, 1'b0, 1'b0);
        repeat (4) rbit(1'b0);
        repeat (3) rbit(1'b1);
        chk("t2_delim_dom", 8, 1, 0, 1'b0, 1'b1); rbit(1'b0);
        repeat (7) rbit(1'b1);
        chk("t2_delim_restart", 8, 1, 0, 1'b1, 1'b1); rbit(1'b1);
        chk("t2_tx_ok", 7, 1, 0, 1'b1, 1'b1); drive_bit(1'b1, NOF, 1'b1, 1'b0, 1'b1);
        chk("t2_rx_ok", 7, 0, 0, 1'b1, 1'b1); drive_bit(1'b1, NOF, 1'b0, 1'b1, 1'b0);
        chk("t2_rx_ok_zero", 7, 0, 0, 1'b1, 1'b1); drive_bit(1'b1, NOF, 1'b0, 1'b1, 1'b0);

        // error-passive via 16 transmit errors; passive flag is recessive
        do_reset("t3_reset");
        repeat (15) err_frame(BIT, 1'b1);
        chk("t3_tec128", 128, 0, 1, 1'b0, 1'b0); drive_bit(1'b0, BIT, 1'b1, 1'b0, 1'b0);
        finish_frame();
        chk("t3_passive_err", 128, 1, 1, 1'b0, 1'b1); drive_bit(1'b0, CRC, 1'b0, 1'b0, 1'b0);
        repeat (2) rbit(1'b0);
        chk("t3_passive_flag", 128, 1, 1, 1'b0, 1'b1); rbit(1'b0);
        repeat (3) rbit(1'b0);
        repeat (8) rbit(1'b1);
        chk("t3_back_active", 127, 1, 0, 1'b1, 1'b1); drive_bit(1'b1, NOF, 1'b1, 1'b0, 1'b1);

        // receive counter boundaries, restore and priority over rx_ok
        do_reset("t4_reset");
        repeat (126) err_frame(EOF, 1'b0);
        chk("t4_rec127", 0, 127, 0, 1'b0, 1'b0); drive_bit(1'b0, EOF, 1'b0, 1'b0, 1'b0);
        finish_frame();
        chk("t4_rec128", 0, 128, 1, 1'b0, 1'b0); drive_bit(1'b0, EOF, 1'b0, 1'b0, 1'b0);
        finish_frame();
        repeat (2) err_frame(EOF, 1'b0);
        chk("t4_rx_ok_restore", 0, 120, 0, 1'b1, 1'b1); drive_bit(1'b1, NOF, 1'b0, 1'b1, 1'b0);
        chk("t4_err_beats_rx_ok", 0, 121, 0, 1'b0, 1'b0); drive_bit(1'b0, BIT, 1'b0, 1'b1, 1'b0);
        finish_frame();

        // bus-off and recovery
        do_reset("t5_reset");
        repeat (2) err_frame(FRM, 1'b0);
        repeat (31) err_frame(BIT, 1'b1);
        chk("t5_tec248", 248, 2, 1, 1'b1, 1'b1); rbit(1'b1);
        drive_bit(1'b0, BIT, 1'b1, 1'b0, 1'b0);
        chk("t5_busoff", 256, 2, 2, 1'b1, 1'b1); drive_bit(1'b0, BIT, 1'b1, 1'b0, 1'b0);
        repeat (9) rbit(1'b1);
        rbit(1'b0);
        repeat (127) repeat (11) rbit(1'b1);
        repeat (9) rbit(1'b1);
        chk("t5_run128_bit10", 256, 2, 2, 1'b1, 1'b1); rbit(1'b1);
        chk("t5_recovered", 0, 0, 0, 1'b1, 1'b1); rbit(1'b1);

        // warning threshold and asynchronous reset mid-flag
        do_reset("t6_reset");
        repeat (10) err_frame(BIT, 1'b1);
        chk("t6_tec88", 88, 0, 0, 1'b0, 1'b0); drive_bit(1'b0, BIT, 1'b1, 1'b0, 1'b0);
        finish_frame();
        chk("t6_tec96", 96, 0, 0, 1'b0, 1'b0); drive_bit(1'b0, BIT, 1'b1, 1'b0, 1'b0);
        finish_frame();
        chk("t6_tec104", 104, 0, 0, 1'b0, 1'b0); drive_bit(1'b0, STF, 1'b1, 1'b0, 1'b0);
        rbit(1'b0);
        chk("t6_mid_flag", 104, 0, 0, 1'b0, 1'b0); rbit(1'b0);
        do_reset("t6_async_reset");
        chk("t6_after_reset", 0, 0, 0, 1'b1, 1'b1); rbit(1'b1);

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no output event, want check at sp %0d", names.pop_front(), q[0].seq);
            void'(q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
